fir_coeff_loader: RTL and testbench
===================================

Name: fir_coeff_loader

Overview:
Sequencer that programs and verifies the 32 tap coefficients of the transposed FIR filter through its coefficient-memory port. A host streams coefficients over a valid/ready handshake. The block writes them sequentially (address 0..NUMTAPS-1), keeps a shadow copy, reads every tap back, and reports pass/fail with a mismatch count and the first failing address. It sits between the host/config interface and the FIR's write_address/write_value/load/read_address/read_value nets.

Parameters:
NUMTAPS, 32, number of coefficients to load and verify (1..256)
DW, 12, coefficient width
AW, 8, coefficient address width

Ports:
Clk  input  1  global clock, all logic on rising edge
Reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a load+verify sequence
abort  input  1  terminates any sequence in progress
coeff_valid  input  1  host coefficient beat valid
coeff_data  input  DW  host coefficient value
coeff_ready  output  1  block accepts a beat this cycle
write_address  output  AW  FIR coefficient write address
write_value  output  DW  FIR coefficient write data
load  output  1  FIR coefficient write enable
read_address  output  AW  FIR coefficient read address
read_value  input  DW  FIR readback; registered in the FIR one cycle after read_address
busy  output  1  sequence in progress
done  output  1  sequence finished; held until next accepted start
error  output  1  at least one readback mismatch; valid when done=1
err_count  output  AW+1  number of mismatching taps (0..NUMTAPS)
first_err_addr  output  AW  lowest mismatching address; 0 if none

Behaviour:
- Reset (async, Reset_n=0): state IDLE. All outputs 0; beat index, shadow registers and compare pipeline cleared.
- All outputs are driven from registers except coeff_ready, which is decoded combinationally from state (=1 only in LOAD).
- IDLE: start=1 -> LOAD at next edge. On this transition busy=1, done=0, error=0, err_count=0, first_err_addr=0, idx=0.
- Start outside IDLE/DONE is ignored. DONE behaves as IDLE for start; done stays 1 until a start is accepted.
- LOAD: a beat is accepted when coeff_valid&coeff_ready.
  - On the accepting edge: write_address<=idx, write_value<=coeff_data, load<=1, shadow[idx]<=coeff_data, idx<=idx+1.
  - load is 1 for exactly one cycle per accepted beat and 0 otherwise.
  - Gaps in coeff_valid stall the sequence without timeout.
  - The edge accepting beat NUMTAPS-1 moves to VERIFY with idx=0; the final load pulse overlaps the first VERIFY cycle.
- VERIFY: one read per cycle.
  - Cycle v (v=0..NUMTAPS-1): read_address=v.
  - An issue flag and address delayed by two stages align the compare: the sample of read_value at the edge ending cycle v+2 is compared against shadow[v].
  - The first read is issued the cycle after the last write edge, so FIR data is already updated.
  - On mismatch: err_count+=1; if it is the first mismatch, first_err_addr<=v.
  - After the compare for v=NUMTAPS-1: state DONE, busy=0, done=1, error=(err_count_final!=0).
  - Idle read_address holds its last value.
- Total latency with coeff_valid held high: start edge -> done=1 is NUMTAPS (load) + NUMTAPS+2 (verify) + 1 cycles = 67 for NUMTAPS=32.
- abort=1 in LOAD or VERIFY: next edge -> IDLE, busy=0, load=0, done=0, error=0. Counters and status are cleared; shadow and FIR contents are left as written. abort has priority over start and over beat acceptance in the same cycle. abort in IDLE/DONE has no effect.
- write_address/read_address upper bits are 0 when NUMTAPS < 2^AW. err_count cannot overflow (AW+1 bits).
- Reset_n low mid-sequence: immediate return to reset state. A partial FIR load is not rolled back.

Test Plan:
- Ramp load: start, coeff_valid=1 with coeff_data=0..31, FIR model ideal -> 32 single-cycle load pulses with write_address=k/write_value=k; done=1 at cycle 67, error=0, err_count=0.
- Bubbles: coeff_valid toggled 1,0,0,1,... with values -3 (0xFFD), 0, 1, 4 ... -> coeff_ready only in LOAD, no beat lost or duplicated, shadow equals input, done with error=0.
- Corrupted readback: FIR model returns value^1 at addresses 5 and 20 -> error=1, err_count=2, first_err_addr=5.
- start asserted during LOAD beat 10 and during VERIFY -> ignored, sequence completes unchanged. start in DONE -> new sequence, status cleared.
- abort at beat 10 together with coeff_valid=1 -> beat not accepted, load=0 next cycle, IDLE, done=0. Next start reloads from address 0.
- Reset_n pulsed low during VERIFY v=15 -> all outputs 0 asynchronously, state IDLE. A later full run passes.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// Loads the FIR coefficient memory from a host stream, keeps a shadow copy,
// then reads every tap back and reports mismatches.
module fir_coeff_loader #(
    parameter int unsigned NUMTAPS = 32,
    parameter int unsigned DW      = 12,
    parameter int unsigned AW      = 8
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic          coeff_valid,
    input  logic [DW-1:0] coeff_data,
    output logic          coeff_ready,
    output logic [AW-1:0] write_address,
    output logic [DW-1:0] write_value,
    output logic          load,
    output logic [AW-1:0] read_address,
    input  logic [DW-1:0] read_value,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW:0]   err_count,
    output logic [AW-1:0] first_err_addr
);

    localparam int unsigned   IW       = (NUMTAPS > 1) ? $clog2(NUMTAPS) : 1;
    localparam logic [AW-1:0] LastAddr = AW'(NUMTAPS - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StVerify, StFinish, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_val_q, wr_val_d;
    logic          load_q, load_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          issue_q, issue_d;
    logic          iss1_q, iss1_d;
    logic          iss2_q, iss2_d;
    logic [AW-1:0] a1_q, a1_d;
    logic [AW-1:0] a2_q, a2_d;
    logic [DW-1:0] rv_q, rv_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [AW:0]   err_cnt_q, err_cnt_d;
    logic [AW-1:0] first_err_q, first_err_d;
    logic [DW-1:0] shadow_q [NUMTAPS];

    logic beat;
    logic mismatch;

    assign coeff_ready = (state_q == StLoad);
    assign beat        = coeff_ready && coeff_valid && !abort;
    assign mismatch    = (rv_q != shadow_q[a2_q[IW-1:0]]);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wr_addr_d   = wr_addr_q;
        wr_val_d    = wr_val_q;
        load_d      = 1'b0;
        rd_addr_d   = rd_addr_q;
        issue_d     = issue_q;
        iss1_d      = issue_q;
        a1_d        = rd_addr_q;
        rv_d        = read_value;
        iss2_d      = iss1_q;
        a2_d        = a1_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;

        if (abort && (state_q inside {StLoad, StVerify, StFinish})) begin
            state_d     = StIdle;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            error_d     = 1'b0;
            err_cnt_d   = '0;
            first_err_d = '0;
            idx_d       = '0;
            issue_d     = 1'b0;
            iss1_d      = 1'b0;
            iss2_d      = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d     = StLoad;
                        busy_d      = 1'b1;
                        done_d      = 1'b0;
                        error_d     = 1'b0;
                        err_cnt_d   = '0;
                        first_err_d = '0;
                        idx_d       = '0;
                    end
                end
                StLoad: begin
                    if (beat) begin
                        wr_addr_d = idx_q;
                        wr_val_d  = coeff_data;
                        load_d    = 1'b1;
                        idx_d     = idx_q + AW'(1);
                        if (idx_q == LastAddr) begin
                            state_d   = StVerify;
                            idx_d     = '0;
                            rd_addr_d = '0;
                            issue_d   = 1'b1;
                        end
                    end
                end
                StVerify: begin
                    if (issue_q) begin
                        if (rd_addr_q == LastAddr) begin
                            issue_d = 1'b0;
                        end else begin
                            rd_addr_d = rd_addr_q + AW'(1);
                        end
                    end
                    // Stage 2 holds the FIR readback captured one edge earlier.
                    if (iss2_q) begin
                        if (mismatch) begin
                            err_cnt_d = err_cnt_q + (AW+1)'(1);
                            if (err_cnt_q == '0) begin
                                first_err_d = a2_q;
                            end
                        end
                        if (a2_q == LastAddr) begin
                            state_d = StFinish;
                        end
                    end
                end
                StFinish: begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    error_d = (err_cnt_q != '0);
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            wr_addr_q   <= '0;
            wr_val_q    <= '0;
            load_q      <= 1'b0;
            rd_addr_q   <= '0;
            issue_q     <= 1'b0;
            iss1_q      <= 1'b0;
            iss2_q      <= 1'b0;
            a1_q        <= '0;
            a2_q        <= '0;
            rv_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wr_addr_q   <= wr_addr_d;
            wr_val_q    <= wr_val_d;
            load_q      <= load_d;
            rd_addr_q   <= rd_addr_d;
            issue_q     <= issue_d;
            iss1_q      <= iss1_d;
            iss2_q      <= iss2_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            rv_q        <= rv_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUMTAPS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (beat) begin
            shadow_q[idx_q[IW-1:0]] <= coeff_data;
        end
    end

    assign write_address  = wr_addr_q;
    assign write_value    = wr_val_q;
    assign load           = load_q;
    assign read_address   = rd_addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign err_count      = err_cnt_q;
    assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: table of load/verify runs against
// a FIR memory model, with a write scoreboard and hand-written abort/reset cases.
module tb_fir_coeff_loader;

    localparam int NUMTAPS = 32;
    localparam int DW      = 12;
    localparam int AW      = 8;

    logic          Clk;
    logic          Reset_n;
    logic          start;
    logic          abort;
    logic          coeff_valid;
    logic [DW-1:0] coeff_data;
    logic          coeff_ready;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_value;
    logic          load;
    logic [AW-1:0] read_address;
    logic [DW-1:0] read_value;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err_addr;

    fir_coeff_loader #(
        .NUMTAPS(NUMTAPS),
        .DW     (DW),
        .AW     (AW)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .start         (start),
        .abort         (abort),
        .coeff_valid   (coeff_valid),
        .coeff_data    (coeff_data),
        .coeff_ready   (coeff_ready),
        .write_address (write_address),
        .write_value   (write_value),
        .load          (load),
        .read_address  (read_address),
        .read_value    (read_value),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_count     (err_count),
        .first_err_addr(first_err_addr)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // FIR coefficient memory model with optional bit-0 corruption on readback.
    logic [DW-1:0]      fir_mem [256];
    logic [NUMTAPS-1:0] corrupt;

    always @(posedge Clk) begin
        if (load) fir_mem[write_address] <= write_value;
        read_value <= fir_mem[read_address] ^ DW'(corrupt[read_address[4:0]]);
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] val;
    } sb_t;

    typedef struct {
        string       name;
        bit          gaps;
        int          dmode;
        logic [31:0] mask;
        int          start_beat;
        bit          start_ver;
        bit          exp_err;
        int          exp_cnt;
        int          exp_first;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[6];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   t_start;
    int   last_drive;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Advance one cycle and retire any write the DUT produced.
    task automatic tick();
        sb_t e;
        @(negedge Clk);
        cyc++;
        if (load === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL load_extra: load=1 addr %0h, expected no write", write_address);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(write_address), 32'(e.addr));
                chk("wr_val", 32'(write_value), 32'(e.val));
            end
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int dmode, input int k);
        case (dmode)
            0:       return DW'(k);
            1:       return (k == 0) ? 12'hFFD : DW'((k - 1) * (k - 1));
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic start_seq();
        start = 1'b1;
        tick();
        start   = 1'b0;
        t_start = cyc;
        chk("busy_after_start", 32'(busy), 1);
        chk("done_after_start", 32'(done), 0);
        chk("err_after_start", 32'(error), 0);
        chk("cnt_after_start", 32'(err_count), 0);
        chk("first_after_start", 32'(first_err_addr), 0);
    endtask

    task automatic drive_beats(input int dmode, input bit gaps, input int start_beat,
                               input int n);
        int k = 0;
        int p = 0;
        int guard = 0;
        bit v;
        sb_t e;
        while (k < n && guard < 1000) begin
            chk("coeff_ready_load", 32'(coeff_ready), 1);
            v = gaps ? (p % 3 == 0) : 1'b1;
            p++;
            coeff_valid = v;
            coeff_data  = v ? beat_data(dmode, k) : DW'($urandom);
            start       = (v && k == start_beat);
            if (v) begin
                e.addr = AW'(k);
                e.val  = coeff_data;
                sb.push_back(e);
                last_drive = cyc;
                k++;
            end
            tick();
            start = 1'b0;
            guard++;
        end
        coeff_valid = 1'b0;
        if (k < n) chk("load_timeout", 32'(k), 32'(n));
    endtask

    task automatic run_vec(input vec_t vc);
        int guard = 0;
        int exp_lat;
        corrupt = vc.mask;
        start_seq();
        drive_beats(vc.dmode, vc.gaps, vc.start_beat, NUMTAPS);
        chk({vc.name, "_ready_verify"}, 32'(coeff_ready), 0);
        while (done !== 1'b1 && guard < 300) begin
            if (vc.start_ver && cyc - t_start == 45) start = 1'b1;
            tick();
            start = 1'b0;
            guard++;
        end
        exp_lat = vc.gaps ? (last_drive - t_start + 36) : (2 * NUMTAPS + 3);
        chk({vc.name, "_latency"}, 32'(cyc - t_start), 32'(exp_lat));
        chk({vc.name, "_done"}, 32'(done), 1);
        chk({vc.name, "_busy"}, 32'(busy), 0);
        chk({vc.name, "_error"}, 32'(error), 32'(vc.exp_err));
        chk({vc.name, "_err_count"}, 32'(err_count), 32'(vc.exp_cnt));
        chk({vc.name, "_first_err"}, 32'(first_err_addr), 32'(vc.exp_first));
        chk({vc.name, "_sb_empty"}, 32'(sb.size()), 0);
        tick();
        chk({vc.name, "_done_held"}, 32'(done), 1);
    endtask

    initial begin
        int guard;

        vecs[0] = '{"ramp",      0, 0, 32'h0,        -1, 0, 0, 0,  0};
        vecs[1] = '{"bubbles",   1, 1, 32'h0,        -1, 0, 0, 0,  0};
        vecs[2] = '{"corrupt",   0, 0, 32'h0010_0020, -1, 0, 1, 2,  5};
        vecs[3] = '{"start_ign", 0, 2, 32'h0,        10, 1, 0, 0,  0};
        vecs[4] = '{"all_bad",   0, 2, 32'hFFFF_FFFF, -1, 0, 1, 32, 0};
        vecs[5] = '{"ends_bad",  0, 2, 32'h8000_0001, -1, 0, 1, 2,  0};

        Reset_n     = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        coeff_valid = 1'b0;
        coeff_data  = '0;
        corrupt     = '0;
        repeat (2) @(negedge Clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_load", 32'(load), 0);
        chk("rst_ready", 32'(coeff_ready), 0);
        chk("rst_err_count", 32'(err_count), 0);
        Reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Abort together with a valid beat: beat must not be written.
        corrupt = '0;
        start_seq();
        drive_beats(0, 1'b0, -1, 10);
        coeff_valid = 1'b1;
        coeff_data  = 12'hABC;
        abort       = 1'b1;
        tick();
        abort       = 1'b0;
        coeff_valid = 1'b0;
        chk("abort_load", 32'(load), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_ready", 32'(coeff_ready), 0);
        tick();
        chk("abort_idle_ready", 32'(coeff_ready), 0);
        run_vec(vecs[0]);

        // Asynchronous reset in the middle of verify.
        start_seq();
        drive_beats(2, 1'b0, -1, NUMTAPS);
        guard = 0;
        while (read_address !== AW'(15) && guard < 100) begin
            tick();
            guard++;
        end
        chk("reach_v15", 32'(read_address), 15);
        #1 Reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_load", 32'(load), 0);
        chk("arst_ready", 32'(coeff_ready), 0);
        chk("arst_rd_addr", 32'(read_address), 0);
        chk("arst_wr_addr", 32'(write_address), 0);
        chk("arst_wr_val", 32'(write_value), 0);
        chk("arst_done", 32'(done), 0);
        tick();
        Reset_n = 1'b1;
        tick();
        chk("arst_sb_empty", 32'(sb.size()), 0);
        run_vec(vecs[2]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
